// File: rtl/uart_rx_if.sv
// Serial receive bundle: line and baud handshake in, received byte and status out.
interface uart_rx_if;
    logic       rs232_rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       frame_err;

    modport slave  (input  rs232_rx, clk_bps,
                    output bps_start, rx_data, rx_int, frame_err);
    modport master (output rs232_rx, clk_bps,
                    input  bps_start, rx_data, rx_int, frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, start-bit validation, LSB-first data shift,
// stop-bit check; bit timing comes from an external baud generator via clk_bps.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    uart_rx_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [2:0] LAST  = 3'(DATA_BITS - 1);

    logic       r_sync0, r_sync1, r_dly;
    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_bps_start, r_rx_int, r_frame_err;
    logic       w_fall;

    // Flops reset high so a line that is already idle produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_dly   <= 1'b1;
        end else begin
            r_sync0 <= bus.rs232_rx;
            r_sync1 <= r_sync0;
            r_dly   <= r_sync1;
        end
    end

    assign w_fall = r_dly & ~r_sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_bps_start <= 1'b0;
            r_rx_int    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state     <= START;
                        r_bps_start <= 1'b1;
                    end
                end
                START: begin
                    if (bus.clk_bps) begin
                        if (!r_sync1) begin
                            r_state  <= DATA;
                            r_rx_int <= 1'b1;
                            r_cnt    <= 3'd0;
                            r_shift  <= 8'h00;
                        end else begin
                            r_state     <= IDLE;
                            r_bps_start <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    // Bits above DATA_BITS are never written, so they stay 0.
                    if (bus.clk_bps) begin
                        r_shift[r_cnt] <= r_sync1;
                        if (r_cnt == LAST) begin
                            r_cnt   <= 3'd0;
                            r_state <= STOP;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bus.clk_bps) begin
                        r_rx_data   <= r_shift;
                        r_bps_start <= 1'b0;
                        r_rx_int    <= 1'b0;
                        r_frame_err <= ~r_sync1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.bps_start = r_bps_start;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_int    = r_rx_int;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit and a 7-bit receiver, each with a
// simple baud generator model and a negedge monitor of the output events.
module tb_uart_rx;
    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_if if8 ();
    uart_rx_if if7 ();

    uart_rx #(.DATA_BITS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    uart_rx #(.DATA_BITS(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));

    logic [1:0]      line;
    logic [1:0]      pulse;
    logic [1:0]      bps_w, int_w, fe_w;
    logic [1:0][7:0] data_w;

    assign if8.rs232_rx = line[0];
    assign if7.rs232_rx = line[1];
    assign if8.clk_bps  = pulse[0];
    assign if7.clk_bps  = pulse[1];
    assign bps_w  = {if7.bps_start, if8.bps_start};
    assign int_w  = {if7.rx_int,    if8.rx_int};
    assign fe_w   = {if7.frame_err, if8.frame_err};
    assign data_w = {if7.rx_data,   if8.rx_data};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator: first pulse half a bit after bps_start, then every bit.
    int bcnt[2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!bps_w[i]) begin
                bcnt[i]  <= 0;
                pulse[i] <= 1'b0;
            end else begin
                bcnt[i]  <= (bcnt[i] == BIT - 1) ? 0 : bcnt[i] + 1;
                pulse[i] <= (bcnt[i] == BIT / 2 - 1);
            end
        end
    end

    int falls[2], rises[2], bps_rises[2], fe_cnt[2], lat_bad[2], chg_bad[2], t_bps[2];
    int q8[$];
    logic [1:0]      prv_int, prv_bps, prv_pls;
    logic [1:0][7:0] prv_data;
    int t_line;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n === 1'b1) begin
                if (prv_int[i] && !int_w[i]) begin
                    falls[i]++;
                    if (i == 0) q8.push_back(int'(data_w[i]));
                    if (!prv_pls[i]) lat_bad[i]++;
                end else if (data_w[i] !== prv_data[i]) begin
                    chg_bad[i]++;
                end
                if (!prv_int[i] && int_w[i]) rises[i]++;
                if (!prv_bps[i] && bps_w[i]) begin
                    bps_rises[i]++;
                    t_bps[i] = cyc;
                end
                if (fe_w[i]) fe_cnt[i]++;
            end
            prv_int[i]  = int_w[i];
            prv_bps[i]  = bps_w[i];
            prv_pls[i]  = pulse[i];
            prv_data[i] = data_w[i];
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            falls[i] = 0; rises[i] = 0; bps_rises[i] = 0;
            fe_cnt[i] = 0; lat_bad[i] = 0; chg_bad[i] = 0; t_bps[i] = 0;
        end
        q8.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop bit left on the line afterwards; a high stop is the idle level.
    task automatic send(input logic [7:0] d, input int idx, input int nbits, input logic stop);
        line[idx] = 1'b0;
        t_line = cyc;
        idle(BIT);
        for (int b = 0; b < nbits; b++) begin
            line[idx] = d[b];
            idle(BIT);
        end
        line[idx] = stop;
        idle(BIT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        line  = 2'b11;
        rst_n = 1'b0;
        idle(5);
        chk("rst_data",  32'(data_w[0]), 32'h00);
        chk("rst_int",   32'(int_w[0]),  32'h0);
        chk("rst_bps",   32'(bps_w[0]),  32'h0);
        chk("rst_fe",    32'(fe_w[0]),   32'h0);
        chk("rst_data7", 32'(data_w[1]), 32'h00);
        rst_n = 1'b1;
        idle(5);

        // 0x55, valid stop
        clr();
        send(8'h55, 0, 8, 1'b1);
        idle(2 * BIT);
        chk("s55_bps_dly", 32'(t_bps[0] - t_line), 32'd3);
        chk("s55_data",  32'(data_w[0]), 32'h55);
        chk("s55_falls", 32'(falls[0]),  32'd1);
        chk("s55_rises", 32'(rises[0]),  32'd1);
        chk("s55_fe",    32'(fe_cnt[0]), 32'd0);
        chk("s55_lat",   32'(lat_bad[0]), 32'd0);
        chk("s55_bpslo", 32'(bps_w[0]),  32'h0);

        // 0xA3 then 0x00 back-to-back
        clr();
        send(8'hA3, 0, 8, 1'b1);
        send(8'h00, 0, 8, 1'b1);
        idle(2 * BIT);
        chk("b2b_falls", 32'(falls[0]), 32'd2);
        chk("b2b_d0",    (q8.size() > 0) ? 32'(q8[0]) : 32'hDEAD, 32'hA3);
        chk("b2b_d1",    (q8.size() > 1) ? 32'(q8[1]) : 32'hDEAD, 32'h00);
        chk("b2b_fe",    32'(fe_cnt[0]), 32'd0);
        chk("b2b_lat",   32'(lat_bad[0]), 32'd0);
        chk("b2b_chg",   32'(chg_bad[0]), 32'd0);

        // 0.3-bit glitch: false start
        clr();
        line[0] = 1'b0;
        idle(5);
        line[0] = 1'b1;
        idle(3 * BIT);
        chk("gl_bps_rises", 32'(bps_rises[0]), 32'd1);
        chk("gl_bpslo",     32'(bps_w[0]),     32'h0);
        chk("gl_rises",     32'(rises[0]),     32'd0);
        chk("gl_data",      32'(data_w[0]),    32'h00);
        chk("gl_chg",       32'(chg_bad[0]),   32'd0);

        // 0xFF with stop bit low
        clr();
        send(8'hFF, 0, 8, 1'b0);
        line[0] = 1'b1;
        idle(2 * BIT);
        chk("fe_data",  32'(data_w[0]), 32'hFF);
        chk("fe_cnt",   32'(fe_cnt[0]), 32'd1);
        chk("fe_falls", 32'(falls[0]),  32'd1);
        chk("fe_lat",   32'(lat_bad[0]), 32'd0);

        // reset during data bit 4 of 0x3C, then clean 0x81
        clr();
        line[0] = 1'b0;
        idle(BIT);
        for (int b = 0; b < 4; b++) begin
            line[0] = 1'(8'h3C >> b);
            idle(BIT);
        end
        line[0] = 1'b1;
        idle(BIT / 2);
        rst_n = 1'b0;
        idle(3);
        chk("ab_rst_data", 32'(data_w[0]), 32'h00);
        rst_n = 1'b1;
        idle(3 * BIT);
        chk("ab_falls", 32'(falls[0]), 32'd0);
        chk("ab_rises", 32'(rises[0]), 32'd1);
        chk("ab_int",   32'(int_w[0]), 32'h0);
        clr();
        send(8'h81, 0, 8, 1'b1);
        idle(2 * BIT);
        chk("ab_falls81", 32'(falls[0]),  32'd1);
        chk("ab_data81",  32'(data_w[0]), 32'h81);

        // 7-bit receiver: 0x5A, then 0x15 with low stop and line held low
        clr();
        send(8'h5A, 1, 7, 1'b1);
        idle(2 * BIT);
        chk("d7_data",  32'(data_w[1]),    32'h5A);
        chk("d7_bit7",  32'(data_w[1][7]), 32'h0);
        chk("d7_falls", 32'(falls[1]),     32'd1);
        chk("d7_fe",    32'(fe_cnt[1]),    32'd0);
        clr();
        send(8'h15, 1, 7, 1'b0);
        idle(20 * BIT);
        chk("brk_falls", 32'(falls[1]),     32'd1);
        chk("brk_data",  32'(data_w[1]),    32'h15);
        chk("brk_fe",    32'(fe_cnt[1]),    32'd1);
        chk("brk_bps",   32'(bps_rises[1]), 32'd1);
        chk("brk_bpslo", 32'(bps_w[1]),     32'h0);
        chk("brk_lat",   32'(lat_bad[1]),   32'd0);
        chk("brk_iso8",  32'(falls[0]),     32'd0);
        line[1] = 1'b1;
        idle(BIT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, giving the number of data bits per frame; the legal range is 5..8.
REQ-002 The module SHALL have port clk, input, 1 bit, the 50 MHz main clock; all logic is in this single clock domain.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have port rs232_rx, input, 1 bit, the asynchronous serial line; it idles high.
REQ-005 The module SHALL have port clk_bps, input, 1 bit, a one-clk pulse from the baud generator at each bit centre while bps_start is high.
REQ-006 The module SHALL have port bps_start, output, 1 bit, the request that starts the baud generator.
REQ-007 The module SHALL have port rx_data, output, 8 bits, the received byte, LSB first on the line; bits [7:DATA_BITS] SHALL be 0.
REQ-008 The module SHALL have port rx_int, output, 1 bit, high while a validated frame is in progress; its falling edge marks rx_data as valid.
REQ-009 The module SHALL have port frame_err, output, 1 bit, a one-clk pulse when the stop bit of a frame is sampled low.

Function
REQ-010 rs232_rx SHALL pass through two synchronizer flops, then one delay flop; a falling edge is detected as delay-flop high AND second-sync-flop low.
REQ-011 The receiver SHALL have the states IDLE, START, DATA, STOP.
REQ-012 Edge detection SHALL take effect only in IDLE; in all other states edges are ignored.
REQ-013 In IDLE, on a detected falling edge the receiver SHALL go to START and bps_start SHALL be registered high on the next clk.
REQ-014 In IDLE, clk_bps pulses SHALL be ignored.
REQ-015 In START, the first clk_bps pulse SHALL sample the synchronized line; if 0, the receiver goes to DATA and rx_int goes high on the next clk.
REQ-016 In START, if the sample is 1 (false start), the receiver goes to IDLE, bps_start goes low on the next clk, rx_int stays low, and rx_data is unchanged.
REQ-017 In DATA, each clk_bps pulse SHALL shift the sample into a shift register at bit position count; the receiver leaves DATA after DATA_BITS pulses; the bit counter wraps to 0.
REQ-018 In STOP, the next clk_bps pulse SHALL sample the stop bit, load rx_data from the shift register regardless of the stop value, and return to IDLE.
REQ-019 On that STOP sample, bps_start and rx_int SHALL both go low on the next clk, and rx_data SHALL be updated on the same edge.
REQ-020 If the stop sample is 0, frame_err SHALL be high for exactly that one clk.
REQ-021 After returning to IDLE, a new frame SHALL require a fresh high-to-low edge; a line held low (break) SHALL NOT retrigger.
REQ-022 The shift register SHALL be internal; rx_data SHALL change only per REQ-018.
REQ-023 rx_int SHALL fall at most once per frame and only after a validated start bit.
REQ-024 Latency SHALL be 1 clk from the stop-bit clk_bps pulse to the rx_int falling edge with valid rx_data.

Reset
REQ-025 While rst_n is low: bps_start=0, rx_int=0, frame_err=0, rx_data=8'h00, state=IDLE, counters=0, synchronizer and delay flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame without an rx_int falling edge; after release, the receiver waits for a new falling edge.

Verification
REQ-027 A frame of 0x55 with a valid stop bit -> bps_start rises 1 clk after edge detect, rx_int rises after the start sample, rx_data=8'h55 and rx_int falls 1 clk after the stop pulse, frame_err stays 0.
REQ-028 Frames 0xA3 then 0x00 back-to-back, with the second start edge right after the stop bit -> rx_data=8'hA3 then 8'h00, two rx_int falling edges.
REQ-029 A 0.3-bit low glitch, with the line high at the first clk_bps -> bps_start pulses then drops, rx_int never rises, rx_data is unchanged.
REQ-030 A 0xFF frame with the stop bit low -> rx_data=8'hFF, frame_err=1 for exactly 1 clk, rx_int falls.
REQ-031 rst_n pulsed low at data bit 4 of 0x3C, then a clean 0x81 frame -> no rx_int edge for the aborted frame; rx_data=8'h81 afterwards.
REQ-032 DATA_BITS=7 with frame 0x5A on the line -> rx_data=8'h5A and bit 7 reads 0; with the line held low 20 bit-times after a frame -> no retrigger.
